// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and helpers for the fifo write-port arbiter and its round-robin picker.
// Counter width below is used only by the FIFO_ARB_STATS_EN build.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    localparam int STAT_WIDTH = 16;

    // Index width for n items, never narrower than one bit.
    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Producer/fifo-facing bundle of the write arbiter: requests, acks, fifo write port, status.
// FIFO_ARB_STATS_EN adds the flattened per-requester write counters (wr_count).
interface fifo_wr_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int ID_WIDTH   = fifo_arb_pkg::id_width(NUM_REQ)
);

    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_ack;
    logic                          fifo_wr_en;
    logic [DATA_WIDTH-1:0]         fifo_wr_data;
    logic                          fifo_wr_ready;
    logic [ID_WIDTH-1:0]           grant_id;
    logic                          busy;
`ifdef FIFO_ARB_STATS_EN
    logic [NUM_REQ*fifo_arb_pkg::STAT_WIDTH-1:0] wr_count;
`endif

    // Producers plus the fifo's ready flag, as seen from outside the arbiter.
    modport master (
        output req, req_data, fifo_wr_ready,
        input  req_ack, fifo_wr_en, fifo_wr_data, grant_id, busy
`ifdef FIFO_ARB_STATS_EN
        , input wr_count
`endif
    );

    modport slave (
        input  req, req_data, fifo_wr_ready,
        output req_ack, fifo_wr_en, fifo_wr_data, grant_id, busy
`ifdef FIFO_ARB_STATS_EN
        , output wr_count
`endif
    );

endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request after i_last, wrapping modulo NUM_REQ.
// Kept standalone so a read-side scheduler can reuse it.
module rr_pick #(
    parameter int NUM_REQ  = 4,
    parameter int ID_WIDTH = fifo_arb_pkg::id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]  i_req,
    input  logic [ID_WIDTH-1:0] i_last,
    output logic [ID_WIDTH-1:0] o_idx,
    output logic                o_any_valid
);

    function automatic logic [ID_WIDTH-1:0] wrap_add(input logic [ID_WIDTH-1:0] base, input int k);
        return ID_WIDTH'((int'(base) + k) % NUM_REQ);
    endfunction

    always_comb begin
        // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
        o_idx       = i_last;
        o_any_valid = |i_req;
        // Walk from farthest to nearest; the nearest set bit after i_last is written last and wins.
        for (int k = NUM_REQ; k >= 1; k--) begin
            if (i_req[wrap_add(i_last, k)]) begin
                o_idx = wrap_add(i_last, k);
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin owner of a single fifo write port shared by NUM_REQ producers, bursts capped at BURST_MAX.
// Define FIFO_ARB_STATS_EN to add saturating per-requester accepted-write counters (bus.wr_count).
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int BURST_MAX  = 4,
    parameter int ID_WIDTH   = id_width(NUM_REQ)
) (
    input logic              clk,
    input logic              reset,
    fifo_wr_arbiter_if.slave bus
);

    localparam int                   CNT_WIDTH  = id_width(BURST_MAX);
    localparam logic [CNT_WIDTH-1:0] BURST_LAST = CNT_WIDTH'(BURST_MAX - 1);

    arb_state_e            r_state,      w_state_nxt;
    logic [ID_WIDTH-1:0]   r_grant_id,   w_grant_nxt;
    logic [ID_WIDTH-1:0]   r_last_grant, w_last_nxt;
    logic [CNT_WIDTH-1:0]  r_burst_cnt,  w_burst_nxt;
    logic [ID_WIDTH-1:0]   w_pick_idx;
    logic                  w_pick_valid;
    logic                  w_req_cur;
    logic                  w_wr_en;
    logic [DATA_WIDTH-1:0] w_wr_data;

    rr_pick #(
        .NUM_REQ  (NUM_REQ),
        .ID_WIDTH (ID_WIDTH)
    ) u_pick (
        .i_req       (bus.req),
        .i_last      (r_last_grant),
        .o_idx       (w_pick_idx),
        .o_any_valid (w_pick_valid)
    );

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            r_state      <= IDLE;
            r_grant_id   <= '0;
            r_last_grant <= ID_WIDTH'(NUM_REQ - 1);
            r_burst_cnt  <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_grant_id   <= w_grant_nxt;
            r_last_grant <= w_last_nxt;
            r_burst_cnt  <= w_burst_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant_id;
        w_last_nxt  = r_last_grant;
        w_burst_nxt = r_burst_cnt;
        w_req_cur   = bus.req[r_grant_id];
        w_wr_en     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_pick_valid) begin
                    w_grant_nxt = w_pick_idx;
                    w_burst_nxt = '0;
                    w_state_nxt = GRANT;
                end
            end
            GRANT: begin
                // Reset gating keeps a reset cycle from acking a word the aborted grant never owns.
                w_wr_en = w_req_cur & bus.fifo_wr_ready & ~reset;
                if (!w_req_cur || (w_wr_en && (r_burst_cnt == BURST_LAST))) begin
                    w_state_nxt = IDLE;
                    w_last_nxt  = r_grant_id;
                end else if (w_wr_en) begin
                    w_burst_nxt = r_burst_cnt + 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_wr_data = '0;
        if (r_state == GRANT) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (r_grant_id == ID_WIDTH'(i)) begin
                    w_wr_data = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    assign bus.fifo_wr_en   = w_wr_en;
    assign bus.fifo_wr_data = w_wr_data;
    assign bus.req_ack      = w_wr_en ? (NUM_REQ'(1) << r_grant_id) : '0;
    assign bus.grant_id     = r_grant_id;
    assign bus.busy         = (r_state == GRANT);

`ifdef FIFO_ARB_STATS_EN
    logic [STAT_WIDTH-1:0] r_wr_count [NUM_REQ];

    always_ff @(posedge clk) begin
        // NOTE: this small counter array is reset explicitly; software reads it as an absolute count.
        if (reset) begin
            for (int i = 0; i < NUM_REQ; i++) r_wr_count[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (bus.req_ack[i] && (r_wr_count[i] != '1)) begin
                    r_wr_count[i] <= r_wr_count[i] + 1'b1;
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_stat
        assign bus.wr_count[g*STAT_WIDTH +: STAT_WIDTH] = r_wr_count[g];
    end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: expected writes are queued as stimulus is set up and popped on fifo_wr_en.
// The FIFO_ARB_STATS_EN build also runs the counter saturation scenario.
module tb_fifo_wr_arbiter;
    import fifo_arb_pkg::*;

    localparam int NR = 4;
    localparam int DW = 8;
    localparam int BM = 4;
    localparam int IW = 2;

    typedef struct packed {
        logic [IW-1:0] id;
        logic [DW-1:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fifo_wr_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ID_WIDTH(IW)) bus ();

    fifo_wr_arbiter #(
        .NUM_REQ    (NR),
        .DATA_WIDTH (DW),
        .BURST_MAX  (BM),
        .ID_WIDTH   (IW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    wr_t           sb[$];
    int            checks   = 0;
    int            failures = 0;
    logic [DW-1:0] dat [NR];
    int            rem [NR];
    logic [NR-1:0] s_ack;
    logic          s_wr_en;
    logic          s_busy;
    logic [DW-1:0] s_data;
    logic [IW-1:0] s_gid;

    task automatic drive_data();
        for (int i = 0; i < NR; i++) bus.req_data[i*DW +: DW] = dat[i];
    endtask

    // n < 0: stream forever; otherwise drop req after n acks.
    task automatic set_req(input int i, input logic [DW-1:0] base, input int n);
        dat[i] = base;
        rem[i] = n;
        bus.req[i] = (n != 0);
        drive_data();
    endtask

    task automatic expect_wr(input int id, input logic [DW-1:0] d);
        sb.push_back('{id: IW'(id), data: d});
    endtask

    // One clock: sample at negedge, then act as the producers just after the posedge.
    task automatic tick();
        @(negedge clk);
        s_ack   = bus.req_ack;
        s_wr_en = bus.fifo_wr_en;
        s_busy  = bus.busy;
        s_data  = bus.fifo_wr_data;
        s_gid   = bus.grant_id;
        @(posedge clk);
        #1;
        for (int i = 0; i < NR; i++) begin
            if (s_ack[i]) begin
                dat[i] = dat[i] + 8'd1;
                if (rem[i] > 0) begin
                    rem[i]--;
                    if (rem[i] == 0) bus.req[i] = 1'b0;
                end
            end
        end
        drive_data();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.req = '0;
        bus.fifo_wr_ready = 1'b1;
        for (int i = 0; i < NR; i++) begin
            dat[i] = '0;
            rem[i] = 0;
        end
        drive_data();
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.req = 4'b1111;
        bus.fifo_wr_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({bus.busy, bus.req_ack, bus.fifo_wr_en, bus.fifo_wr_data, bus.grant_id} !== 16'h0) begin
            failures++;
            $display("FAIL reset_outputs busy=%b ack=%b wr_en=%b data=%h gid=%0d required all zero",
                     bus.busy, bus.req_ack, bus.fifo_wr_en, bus.fifo_wr_data, bus.grant_id);
        end
        do_reset();
    endtask

    task automatic test_single();
        wr_t e;
        do_reset();
        set_req(0, 8'hA1, 1);
        expect_wr(0, 8'hA1);
        tick();
        checks++;
        if ({s_busy, s_wr_en} !== 2'b00) begin
            failures++;
            $display("FAIL single_idle busy=%b wr_en=%b required 0 0", s_busy, s_wr_en);
        end
        tick();
        checks++;
        if ({s_busy, s_gid, s_ack, s_wr_en} !== {1'b1, 2'd0, 4'b0001, 1'b1}) begin
            failures++;
            $display("FAIL single_grant busy=%b gid=%0d ack=%b wr_en=%b required 1 0 0001 1",
                     s_busy, s_gid, s_ack, s_wr_en);
        end
        e = sb.pop_front();
        checks++;
        if ({s_gid, s_data} !== {e.id, e.data}) begin
            failures++;
            $display("FAIL single_write got id=%0d data=%h required id=%0d data=%h", s_gid, s_data, e.id, e.data);
        end
        tick();
        tick();
        checks++;
        if ({s_busy, s_wr_en} !== 2'b00) begin
            failures++;
            $display("FAIL single_release busy=%b wr_en=%b required 0 0", s_busy, s_wr_en);
        end
    endtask

    task automatic test_rotation();
        wr_t e;
        int  idle_cycles = 0;
        int  seen[NR] = '{default: 0};
        int  order[5] = '{0, 1, 2, 3, 0};
        do_reset();
        for (int i = 0; i < NR; i++) set_req(i, DW'(i * 16), -1);
        foreach (order[k]) begin
            for (int b = 0; b < BM; b++) begin
                expect_wr(order[k], DW'(order[k] * 16 + seen[order[k]]));
                seen[order[k]]++;
            end
        end
        for (int c = 0; c < 25; c++) begin
            tick();
            if (!s_busy) idle_cycles++;
            if (s_wr_en === 1'b1) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL rot_write extra write id=%0d data=%h", s_gid, s_data);
                end else begin
                    e = sb.pop_front();
                    if ({s_gid, s_data, s_ack} !== {e.id, e.data, NR'(1) << e.id}) begin
                        failures++;
                        $display("FAIL rot_write got id=%0d data=%h ack=%b required id=%0d data=%h",
                                 s_gid, s_data, s_ack, e.id, e.data);
                    end
                end
            end
        end
        checks++;
        if (idle_cycles != 5 || sb.size() != 0) begin
            failures++;
            $display("FAIL rot_gaps idle=%0d left=%0d required idle=5 left=0", idle_cycles, sb.size());
        end
    endtask

    task automatic test_backpressure();
        wr_t e;
        do_reset();
        set_req(2, 8'h20, -1);
        for (int k = 0; k < 5; k++) expect_wr(2, DW'(8'h20 + k));
        for (int c = 0; c < 12; c++) begin
            if (c == 3) bus.fifo_wr_ready = 1'b0;
            if (c == 8) bus.fifo_wr_ready = 1'b1;
            tick();
            if (c >= 3 && c < 8) begin
                checks++;
                if ({s_wr_en, s_ack, s_busy, s_gid} !== {1'b0, 4'b0000, 1'b1, 2'd2}) begin
                    failures++;
                    $display("FAIL bp_stall cycle=%0d wr_en=%b ack=%b busy=%b gid=%0d required 0 0000 1 2",
                             c, s_wr_en, s_ack, s_busy, s_gid);
                end
            end else if (c == 10) begin
                checks++;
                if ({s_busy, s_wr_en} !== 2'b00) begin
                    failures++;
                    $display("FAIL bp_burst_resume busy=%b wr_en=%b required 0 0 after 4 writes", s_busy, s_wr_en);
                end
            end else if (s_wr_en === 1'b1) begin
                checks++;
                e = sb.pop_front();
                if ({s_gid, s_data} !== {e.id, e.data}) begin
                    failures++;
                    $display("FAIL bp_write got id=%0d data=%h required id=%0d data=%h", s_gid, s_data, e.id, e.data);
                end
            end
        end
        bus.fifo_wr_ready = 1'b0;
        tick();
        set_req(2, dat[2], 0);
        tick();
        checks++;
        if ({s_busy, s_wr_en, s_ack} !== {1'b1, 1'b0, 4'b0000}) begin
            failures++;
            $display("FAIL drop_stalled busy=%b wr_en=%b ack=%b required 1 0 0000", s_busy, s_wr_en, s_ack);
        end
        tick();
        checks++;
        if ({s_busy, s_ack, sb.size() == 0} !== {1'b0, 4'b0000, 1'b1}) begin
            failures++;
            $display("FAIL drop_release busy=%b ack=%b left=%0d required 0 0000 0", s_busy, s_ack, sb.size());
        end
        bus.fifo_wr_ready = 1'b1;
    endtask

    task automatic test_order();
        wr_t  e;
        logic raised = 1'b0;
        do_reset();
        set_req(0, 8'hD0, 1);
        expect_wr(0, 8'hD0);
        expect_wr(2, 8'hE0);
        expect_wr(2, 8'hE1);
        expect_wr(0, 8'hC0);
        expect_wr(0, 8'hC1);
        expect_wr(1, 8'hB0);
        for (int c = 0; c < 19; c++) begin
            tick();
            if (c == 2) begin
                set_req(0, 8'hC0, 2);
                set_req(2, 8'hE0, 2);
            end
            if (s_wr_en === 1'b1) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL order_write extra write id=%0d data=%h", s_gid, s_data);
                end else begin
                    e = sb.pop_front();
                    if ({s_gid, s_data} !== {e.id, e.data}) begin
                        failures++;
                        $display("FAIL order_write got id=%0d data=%h required id=%0d data=%h",
                                 s_gid, s_data, e.id, e.data);
                    end
                end
                if (s_gid == 2'd2 && !raised) begin
                    set_req(1, 8'hB0, 1);
                    raised = 1'b1;
                end
            end
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL order_done left=%0d required 0", sb.size());
        end
    endtask

    task automatic test_reset_mid_burst();
        wr_t e;
        do_reset();
        set_req(3, 8'h30, -1);
        expect_wr(3, 8'h30);
        expect_wr(3, 8'h31);
        for (int c = 0; c < 3; c++) begin
            tick();
            if (s_wr_en === 1'b1) begin
                checks++;
                e = sb.pop_front();
                if ({s_gid, s_data} !== {e.id, e.data}) begin
                    failures++;
                    $display("FAIL mid_write got id=%0d data=%h required id=%0d data=%h", s_gid, s_data, e.id, e.data);
                end
            end
        end
        reset = 1'b1;
        set_req(1, 8'h10, -1);
        tick();
        checks++;
        if ({s_ack, s_wr_en} !== 5'b0) begin
            failures++;
            $display("FAIL mid_reset_cycle ack=%b wr_en=%b required 0000 0", s_ack, s_wr_en);
        end
        tick();
        checks++;
        if ({s_busy, s_ack} !== 5'b0) begin
            failures++;
            $display("FAIL mid_reset_idle busy=%b ack=%b required 0 0000", s_busy, s_ack);
        end
        reset = 1'b0;
        tick();
        tick();
        checks++;
        if ({s_wr_en, s_gid, s_data, s_ack} !== {1'b1, 2'd1, 8'h10, 4'b0010}) begin
            failures++;
            $display("FAIL mid_regrant wr_en=%b gid=%0d data=%h ack=%b required 1 1 10 0010",
                     s_wr_en, s_gid, s_data, s_ack);
        end
    endtask

`ifdef FIFO_ARB_STATS_EN
    task automatic test_stats();
        int            acks[NR] = '{default: 0};
        logic [15:0]   want;
        do_reset();
        set_req(1, 8'h00, -1);
        for (int c = 0; c < 82000; c++) begin
            tick();
            for (int i = 0; i < NR; i++) if (s_ack[i]) acks[i]++;
        end
        checks++;
        if (acks[1] <= 65535) begin
            failures++;
            $display("FAIL stats_volume acks=%0d required above 65535", acks[1]);
        end
        for (int i = 0; i < NR; i++) begin
            want = (acks[i] > 65535) ? 16'hFFFF : 16'(acks[i]);
            checks++;
            if (bus.wr_count[i*STAT_WIDTH +: STAT_WIDTH] !== want) begin
                failures++;
                $display("FAIL stats_count req=%0d got=%h required=%h",
                         i, bus.wr_count[i*STAT_WIDTH +: STAT_WIDTH], want);
            end
        end
    endtask
`endif

    initial begin
        #5_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        bus.req = '0;
        bus.req_data = '0;
        bus.fifo_wr_ready = 1'b1;
        test_reset();
        test_single();
        test_rotation();
        test_backpressure();
        test_order();
        test_reset_mid_burst();
`ifdef FIFO_ARB_STATS_EN
        test_stats();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
